// File: rtl/flex_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flex_cnt_pkg
// Description : Shared types and the next-count rule for flex_multi_counter.
// Revision    : 1.0 - initial release
// ============================================================================
package flex_cnt_pkg;

    localparam int WRAP_CNT_BITS = 8;
    localparam int MAX_CNT_BITS  = 32;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_t;

    // Values are zero-extended to MAX_CNT_BITS so one function serves any lane width.
    function automatic logic [MAX_CNT_BITS-1:0] next_count(
        input logic [MAX_CNT_BITS-1:0] cnt,
        input logic [MAX_CNT_BITS-1:0] rval,
        input cnt_dir_t                dir
    );
        logic [MAX_CNT_BITS-1:0] nxt;
        nxt = cnt;
        if (rval == '0) begin
            nxt = cnt;
        end else if (dir == CNT_UP) begin
            nxt = (cnt >= rval) ? MAX_CNT_BITS'(1) : cnt + MAX_CNT_BITS'(1);
        end else begin
            nxt = ((cnt > rval) || (cnt <= MAX_CNT_BITS'(1))) ? rval : cnt - MAX_CNT_BITS'(1);
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flex_cnt_lane.sv
`default_nettype none
// ============================================================================
// Module      : flex_cnt_lane
// Description : One up/down rollover counter channel with registered terminal
//               flag; optional saturating wrap counter (FLEX_CNT_WRAP_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module flex_cnt_lane
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    count_up,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
`ifdef FLEX_CNT_WRAP_CNT_EN
    ,
    output logic [WRAP_CNT_BITS-1:0] wrap_count
`endif
);

    localparam logic [NUM_CNT_BITS-1:0] c_one = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_flag;
    cnt_dir_t                w_dir;
    logic [MAX_CNT_BITS-1:0] w_adv_wide;
    logic                    w_unused_adv;
    logic [NUM_CNT_BITS-1:0] w_adv;
    logic [NUM_CNT_BITS-1:0] w_load_sat;
    logic                    w_r_nz;
    logic                    w_load_term;
    logic                    w_adv_term;

    assign w_dir        = cnt_dir_t'(count_up);
    assign w_adv_wide   = next_count(MAX_CNT_BITS'(r_count), MAX_CNT_BITS'(rollover_val), w_dir);
    assign w_unused_adv = ^w_adv_wide;
    assign w_adv        = w_adv_wide[NUM_CNT_BITS-1:0];
    assign w_load_sat   = (load_val > rollover_val) ? rollover_val : load_val;
    assign w_r_nz       = |rollover_val;

    // A zero rollover value never produces a terminal, so the flag stays low.
    assign w_load_term = w_r_nz && (count_up ? (w_load_sat == rollover_val) : (w_load_sat == c_one));
    assign w_adv_term  = w_r_nz && (count_up ? (w_adv == rollover_val) : (w_adv == c_one));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else if (load) begin
            r_count <= w_load_sat;
            r_flag  <= w_load_term;
        end else if (count_enable) begin
            r_count <= w_adv;
            r_flag  <= w_adv_term;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;

`ifdef FLEX_CNT_WRAP_CNT_EN
    logic                     w_wrap_evt;
    logic [WRAP_CNT_BITS-1:0] r_wrap;

    // Reaching R from below is not a wrap; only R->1 (up) or 1/0->R (down) is.
    assign w_wrap_evt = w_r_nz && (count_up ? (r_count == rollover_val) : (r_count <= c_one));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wrap <= '0;
        end else if (!load && count_enable && w_wrap_evt && (r_wrap != '1)) begin
            r_wrap <= r_wrap + WRAP_CNT_BITS'(1);
        end
    end

    assign wrap_count = r_wrap;
`endif

endmodule
`default_nettype wire

// File: rtl/flex_multi_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_multi_counter
// Description : Bank of NUM_CH independent rollover counters plus a registered
//               any_rollover summary. Optional macro: FLEX_CNT_WRAP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_multi_counter
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int NUM_CNT_BITS = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                clear,
    input  logic [NUM_CH-1:0]                count_enable,
    input  logic [NUM_CH-1:0]                count_up,
    input  logic [NUM_CH-1:0]                load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0]   load_val,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0]   rollover_val,
    output logic [NUM_CH*NUM_CNT_BITS-1:0]   count_out,
    output logic [NUM_CH-1:0]                rollover_flag,
    output logic                             any_rollover
`ifdef FLEX_CNT_WRAP_CNT_EN
    ,
    output logic [NUM_CH*WRAP_CNT_BITS-1:0]  wrap_count
`endif
);

    logic r_any;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        flex_cnt_lane #(
            .NUM_CNT_BITS (NUM_CNT_BITS)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .clear         (clear[gi]),
            .count_enable  (count_enable[gi]),
            .count_up      (count_up[gi]),
            .load          (load[gi]),
            .load_val      (load_val[gi*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_val  (rollover_val[gi*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .count_out     (count_out[gi*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_flag (rollover_flag[gi])
`ifdef FLEX_CNT_WRAP_CNT_EN
            ,
            .wrap_count    (wrap_count[gi*WRAP_CNT_BITS +: WRAP_CNT_BITS])
`endif
        );
    end

    // Built from the registered flags, so it trails them by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |rollover_flag;
        end
    end

    assign any_rollover = r_any;

endmodule
`default_nettype wire

// File: tb/tb_flex_multi_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_multi_counter
// Description : Directed self-checking bench for flex_multi_counter (4 x 5-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_multi_counter;

    localparam int NCH = 4;
    localparam int W   = 5;

    logic               clk;
    logic               rst;
    logic [NCH-1:0]     clear;
    logic [NCH-1:0]     count_enable;
    logic [NCH-1:0]     count_up;
    logic [NCH-1:0]     load;
    logic [NCH*W-1:0]   load_val;
    logic [NCH*W-1:0]   rollover_val;
    logic [NCH*W-1:0]   count_out;
    logic [NCH-1:0]     rollover_flag;
    logic               any_rollover;
`ifdef FLEX_CNT_WRAP_CNT_EN
    logic [NCH*8-1:0]   wrap_count;
`endif

    logic [W-1:0] lv [NCH];
    logic [W-1:0] rv [NCH];

    int checks   = 0;
    int failures = 0;

    assign load_val     = {lv[3], lv[2], lv[1], lv[0]};
    assign rollover_val = {rv[3], rv[2], rv[1], rv[0]};

    flex_multi_counter #(
        .NUM_CH       (NCH),
        .NUM_CNT_BITS (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .count_enable  (count_enable),
        .count_up      (count_up),
        .load          (load),
        .load_val      (load_val),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .any_rollover  (any_rollover)
`ifdef FLEX_CNT_WRAP_CNT_EN
        ,
        .wrap_count    (wrap_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input int ch, input int exp, input string name);
        checks++;
        if (count_out[ch*W +: W] !== W'(exp)) begin
            failures++;
            $display("FAIL %s ch%0d count got %0d expected %0d", name, ch, count_out[ch*W +: W], exp);
        end
    endtask

    task automatic chk_flag(input int ch, input logic exp, input string name);
        checks++;
        if (rollover_flag[ch] !== exp) begin
            failures++;
            $display("FAIL %s ch%0d flag got %b expected %b", name, ch, rollover_flag[ch], exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = '1; count_enable = '1; count_up = '1; load = '1;
        for (int i = 0; i < NCH; i++) begin lv[i] = 5'd3; rv[i] = 5'd5; end
        tick(); tick();
        checks++;
        if (count_out !== '0) begin failures++; $display("FAIL reset count_out got %h expected 0", count_out); end
        checks++;
        if (rollover_flag !== '0) begin failures++; $display("FAIL reset flags got %b expected 0", rollover_flag); end
        checks++;
        if (any_rollover !== 1'b0) begin failures++; $display("FAIL reset any_rollover got %b expected 0", any_rollover); end
`ifdef FLEX_CNT_WRAP_CNT_EN
        checks++;
        if (wrap_count !== '0) begin failures++; $display("FAIL reset wrap_count got %h expected 0", wrap_count); end
`endif
        rst = 1'b0; clear = '0; count_enable = '0; load = '0;
    endtask

    task automatic test_up_wrap();
        int  exp_seq [12] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
        logic prev_flag;
        prev_flag = 1'b0;
        rv[0] = 5'd5; count_up[0] = 1'b1; count_enable[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_cnt(0, exp_seq[i], "up_wrap");
            chk_flag(0, exp_seq[i] == 5, "up_wrap");
            checks++;
            if (any_rollover !== prev_flag) begin
                failures++;
                $display("FAIL up_wrap any_rollover step %0d got %b expected %b", i, any_rollover, prev_flag);
            end
            prev_flag = (exp_seq[i] == 5);
        end
        count_enable[0] = 1'b0;
    endtask

    task automatic test_down();
        int exp_seq [6] = '{4, 3, 2, 1, 4, 3};
        rv[1] = 5'd4; count_up[1] = 1'b0; count_enable[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_cnt(1, exp_seq[i], "down");
            chk_flag(1, exp_seq[i] == 1, "down");
        end
        count_enable[1] = 1'b0;
        tick();
        chk_cnt(1, 3, "down_hold");
        chk_cnt(0, 2, "independent_hold");
    endtask

    task automatic test_priority();
        rv[2] = 5'd6; lv[2] = 5'd3; count_up[2] = 1'b1;
        clear[2] = 1'b1; load[2] = 1'b1; count_enable[2] = 1'b1;
        tick();
        chk_cnt(2, 0, "clear_wins");
        chk_flag(2, 1'b0, "clear_wins");
        clear[2] = 1'b0;
        tick();
        chk_cnt(2, 3, "load_over_enable");
        chk_flag(2, 1'b0, "load_over_enable");
        lv[2] = 5'd9; count_enable[2] = 1'b0;
        tick();
        chk_cnt(2, 6, "load_saturate");
        chk_flag(2, 1'b1, "load_saturate");
        load[2] = 1'b0; count_enable[2] = 1'b1;
        tick();
        chk_cnt(2, 1, "after_load_wrap");
        chk_flag(2, 1'b0, "after_load_wrap");
        count_enable[2] = 1'b0;
    endtask

    task automatic test_edge_r();
        rv[3] = 5'd0; count_up[3] = 1'b1; count_enable[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_cnt(3, 0, "r_zero_hold");
            chk_flag(3, 1'b0, "r_zero_hold");
        end
        count_enable[3] = 1'b0;
        rv[3] = 5'd7; lv[3] = 5'd6; load[3] = 1'b1;
        tick();
        chk_cnt(3, 6, "load6");
        load[3] = 1'b0; rv[3] = 5'd2; count_enable[3] = 1'b1;
        tick();
        chk_cnt(3, 1, "r_lowered_up");
        chk_flag(3, 1'b0, "r_lowered_up");
        tick();
        chk_cnt(3, 2, "r_lowered_up2");
        chk_flag(3, 1'b1, "r_lowered_up2");
        count_enable[3] = 1'b0;
        rv[3] = 5'd7; load[3] = 1'b1;
        tick();
        load[3] = 1'b0; rv[3] = 5'd3; count_up[3] = 1'b0; count_enable[3] = 1'b1;
        tick();
        chk_cnt(3, 3, "r_lowered_down");
        chk_flag(3, 1'b0, "r_lowered_down");
        count_enable[3] = 1'b0;
    endtask

    task automatic test_mid_reset();
        rv[0] = 5'd5; count_up[0] = 1'b1; count_enable[0] = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk_cnt(0, 0, "mid_reset");
        chk_cnt(3, 0, "mid_reset");
        rst = 1'b0;
        tick();
        chk_cnt(0, 1, "resume");
        count_enable[0] = 1'b0;
    endtask

`ifdef FLEX_CNT_WRAP_CNT_EN
    task automatic test_wrap_count();
        rv[0] = 5'd1; count_up[0] = 1'b1; clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0; count_enable[0] = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        count_enable[0] = 1'b0;
        checks++;
        if (wrap_count[7:0] !== 8'd255) begin failures++; $display("FAIL wrap_sat got %0d expected 255", wrap_count[7:0]); end
        lv[0] = 5'd0; load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        checks++;
        if (wrap_count[7:0] !== 8'd255) begin failures++; $display("FAIL wrap_load_keep got %0d expected 255", wrap_count[7:0]); end
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        checks++;
        if (wrap_count[7:0] !== 8'd0) begin failures++; $display("FAIL wrap_clear got %0d expected 0", wrap_count[7:0]); end
    endtask
`endif

    initial begin
        rst = 1'b1; clear = '0; count_enable = '0; count_up = '0; load = '0;
        for (int i = 0; i < NCH; i++) begin lv[i] = '0; rv[i] = '0; end
        test_reset();
        test_up_wrap();
        test_down();
        test_priority();
        test_edge_r();
        test_mid_reset();
`ifdef FLEX_CNT_WRAP_CNT_EN
        test_wrap_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
